// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// Default geometry and the slice-width helper live here.
package adder_pkg;

  localparam int unsigned N_DEF      = 32;
  localparam int unsigned STAGES_DEF = 4;

  function automatic int unsigned slice_w(
    input int unsigned n,
    input int unsigned s
  );
    return n / s;
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One W-bit ripple slice of the pipelined adder.
// c_msb is the carry entering the slice's top bit.
module add_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b}
                     + {{W{1'b0}}, cin};

  // sum bit = a ^ b ^ carry-in, so the carry is recoverable
  assign c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder/subtractor, STAGES slices of N/STAGES bits.
// Operands skew forward with their carry; lower sums ride along.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned STAGES = STAGES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: STAGES must divide N, 1 <= STAGES <= N");
  end

  localparam int unsigned W = slice_w(N, STAGES);

  logic              advance;
  logic [N-1:0]      a_src  [STAGES];
  logic [N-1:0]      b_src  [STAGES];
  logic [N-1:0]      s_src  [STAGES];
  logic [N-1:0]      sum_d  [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;

  logic [W-1:0]      sl_sum [STAGES];
  logic [STAGES-1:0] sl_cout;
  logic              sl_cm  [STAGES];

  logic [N-1:0]      a_q    [STAGES];
  logic [N-1:0]      b_q    [STAGES];
  logic [N-1:0]      sum_q  [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              cm_q;

  always_comb begin
    advance = !v_q[STAGES-1] || out_ready;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_src[k] = A;
        b_src[k] = sub ? ~B : B;
        c_src[k] = Cin ^ sub;
        v_src[k] = in_valid;
        s_src[k] = '0;
      end else begin
        a_src[k] = a_q[k-1];
        b_src[k] = b_q[k-1];
        c_src[k] = c_q[k-1];
        v_src[k] = v_q[k-1];
        s_src[k] = sum_q[k-1];
      end
      sum_d[k] = s_src[k];
      sum_d[k][k*W +: W] = sl_sum[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_slice #(
      .W (W)
    ) u_slice (
      .a     (a_src[k][k*W +: W]),
      .b     (b_src[k][k*W +: W]),
      .cin   (c_src[k]),
      .sum   (sl_sum[k]),
      .cout  (sl_cout[k]),
      .c_msb (sl_cm[k])
    );
  end

  // Data only loads behind a valid bit, so bubbles never disturb Sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      cm_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_src[k];
        if (v_src[k]) begin
          a_q[k]   <= a_src[k];
          b_q[k]   <= b_src[k];
          sum_q[k] <= sum_d[k];
          c_q[k]   <= sl_cout[k];
        end
      end
      if (v_src[STAGES-1]) begin
        cm_q <= sl_cm[STAGES-1];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign Sum       = sum_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = c_q[STAGES-1] ^ cm_q;

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter N, default 32, operand width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; N % STAGES == 0 and 1 <= STAGES <= N, else elaboration error.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port A  input  N  operand A, unsigned or two's complement.
REQ-008 SHALL have port B  input  N  operand B.
REQ-009 SHALL have port Cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port Sum  output  N  result.
REQ-014 SHALL have port Cout  output  1  raw carry out of the MSB slice.
REQ-015 SHALL have port Ovf  output  1  signed two's-complement overflow.

Function
REQ-016 SHALL compute sub=0: {Cout,Sum} = A + B + Cin; sub=1: {Cout,Sum} = A + ~B + ~Cin (i.e. A - B - Cin; Cout=1 means no borrow).
REQ-017 SHALL set Ovf = carry into MSB XOR Cout.
REQ-018 SHALL split the operands into STAGES slices of W = N/STAGES bits; stage k adds slice k using the carry registered by stage k-1.
REQ-019 SHALL delay not-yet-added upper operand slices and hold already-computed lower Sum slices in skew registers so each transaction stays aligned.
REQ-020 SHALL have a latency of exactly STAGES cycles from accept (in_valid & in_ready at an edge) to out_valid with no stall.
REQ-021 SHALL carry one valid bit per stage; the pipeline advances when advance = !out_valid | out_ready; all stages stall together otherwise.
REQ-022 SHALL drive in_ready = advance (combinational); throughput one transaction per cycle with out_ready held high.
REQ-023 SHALL hold Sum, Cout, Ovf stable while out_valid=1 and out_ready=0.
REQ-024 SHALL propagate bubbles: an advance with in_valid=0 loads a cleared valid bit into stage 0.
REQ-025 SHALL keep transaction order; no drop or duplication under any out_ready pattern.
REQ-026 SHALL behave as a purely registered adder when STAGES=1 (latency 1).
REQ-027 SHALL wrap modulo 2^N: 0xFF..F + 1 gives Sum=0, Cout=1.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear all stage valid bits, carry registers, and skew/data registers to 0.
REQ-029 SHALL drive out_valid=0, Sum=0, Cout=0, Ovf=0 during and after reset until a result reaches the output.
REQ-030 SHALL discard in-flight transactions on reset mid-operation; the first result after release comes from the first post-reset accept.

Structure
REQ-031 SHALL place default N/STAGES constants and a slice-width helper function in shared package adder_pkg.
REQ-032 SHALL use one sub-module, add_slice (parameter W; inputs a, b, cin; outputs sum, cout, c_msb = carry into its top bit), instanced STAGES times by a generate loop.
REQ-033 SHALL contain no latches; all flops reset by rst_n.

Verification
REQ-034 SHALL cover with N=8, STAGES=4, out_ready=1: A=0x3C, B=0x0F, Cin=0, sub=0 -> Sum=0x4B, Cout=0, Ovf=0, out_valid exactly 4 cycles after accept.
REQ-035 SHALL cover full-length ripple: A=0xFF, B=0x00, Cin=1, sub=0 -> Sum=0x00, Cout=1, Ovf=0.
REQ-036 SHALL cover subtract and overflow: A=0x80, B=0x01, Cin=0, sub=1 -> Sum=0x7F, Cout=1, Ovf=1; A=0x7F, B=0x01, sub=0 -> Sum=0x80, Ovf=1.
REQ-037 SHALL cover back-to-back stream of 16 random operand sets with out_ready toggling pseudo-randomly -> results in order, match reference model, outputs stable while stalled, in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-038 SHALL cover reset asserted with 3 transactions in flight -> out_valid=0 immediately, Sum=0; next accepted A=0x01, B=0x01 -> Sum=0x02 after 4 cycles, no stale results.
REQ-039 SHALL cover STAGES=1 and STAGES=8 (N=8) builds with the REQ-034 vector -> same result at latency 1 and 8.
